// File: rtl/remove_header.sv
// ---------------------------------------------------------------------------
// remove_header
//
// Receive-side header stripper. The first beat of every packet carries a
// HDR_BYTES-byte header in byte lanes 0..HDR_BYTES-1. That header is emitted
// on the meta channel. The rest of the packet is shifted down by HDR_BYTES
// bytes and emitted on the output stream.
//
// Handshake semantics (all three channels): a transfer happens on a rising
// clock edge where valid && ready. Once valid is high it stays high, with
// stable bits, until the transfer happens. Ready may depend combinationally
// on the consumer's ready, but never on the producer's valid.
//
// Ports
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   io_in_data_*              input packet stream (data/keep/last)
//   io_out_meta_*             extracted header, one per packet
//   io_out_data_*             re-aligned payload stream (data/keep/last)
//   debug_state               current FSM state (0 FIRST, 1 MID, 2 FLUSH)
// ---------------------------------------------------------------------------
module remove_header #(
    parameter int DATA_BYTES = 64,
    parameter int HDR_BYTES  = 4
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    io_in_data_valid,
    output logic                    io_in_data_ready,
    input  logic [8*DATA_BYTES-1:0] io_in_data_bits_data,
    input  logic [DATA_BYTES-1:0]   io_in_data_bits_keep,
    input  logic                    io_in_data_bits_last,

    output logic                    io_out_meta_valid,
    input  logic                    io_out_meta_ready,
    output logic [8*HDR_BYTES-1:0]  io_out_meta_bits,

    output logic                    io_out_data_valid,
    input  logic                    io_out_data_ready,
    output logic [8*DATA_BYTES-1:0] io_out_data_bits_data,
    output logic [DATA_BYTES-1:0]   io_out_data_bits_keep,
    output logic                    io_out_data_bits_last,

    output logic [1:0]              debug_state
);

    localparam int W  = 8 * DATA_BYTES;        // beat data width
    localparam int KW = DATA_BYTES;            // beat keep width
    localparam int HW = 8 * HDR_BYTES;         // header width
    localparam int RW = W - HW;                // residual data width
    localparam int RK = DATA_BYTES - HDR_BYTES; // residual keep width

    typedef enum logic [1:0] {
        ST_FIRST = 2'd0,
        ST_MID   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Residual: upper bytes of the previous input beat, waiting to be merged
    // with the low bytes of the next one.
    logic [RW-1:0] res_data;
    logic [RK-1:0] res_keep;

    // Slot availability: a 1-entry slot can take a new item if it is empty
    // or is being drained in this same cycle.
    logic data_free;
    logic meta_free;
    logic in_fire;
    logic in_tail_empty;

    // Decoded actions for this cycle (output-comb process).
    logic          load_out;
    logic          load_res;
    logic          load_meta;
    logic [W-1:0]  out_data_next;
    logic [KW-1:0] out_keep_next;
    logic          out_last_next;

    assign data_free = !io_out_data_valid || io_out_data_ready;
    assign meta_free = !io_out_meta_valid || io_out_meta_ready;

    // The meta slot only gates the first beat of a packet; once the header
    // has been captured the payload flows regardless of meta backpressure.
    assign io_in_data_ready = !reset
                              && (state != ST_FLUSH)
                              && data_free
                              && ((state != ST_FIRST) || meta_free);

    assign in_fire       = io_in_data_valid && io_in_data_ready;
    assign in_tail_empty = (io_in_data_bits_keep[KW-1:HDR_BYTES] == '0);

    assign debug_state = state;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FIRST;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_FIRST: begin
                if (in_fire && !io_in_data_bits_last) begin
                    state_next = ST_MID;
                end
            end
            ST_MID: begin
                if (in_fire && io_in_data_bits_last) begin
                    // Upper bytes still populated means the shifted packet
                    // spills into one more output beat.
                    state_next = in_tail_empty ? ST_FIRST : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (data_free) begin
                    state_next = ST_FIRST;
                end
            end
            default: state_next = ST_FIRST;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode (what to load into the slots / residual)
    // -----------------------------------------------------------------------
    always_comb begin
        load_out      = 1'b0;
        load_res      = 1'b0;
        load_meta     = 1'b0;
        out_data_next = '0;
        out_keep_next = '0;
        out_last_next = 1'b0;
        case (state)
            ST_FIRST: begin
                if (in_fire) begin
                    load_meta = 1'b1;
                    if (io_in_data_bits_last) begin
                        // Single-beat packet: shifted payload goes straight
                        // out. A header-only packet still yields one beat,
                        // with keep all zero.
                        load_out      = 1'b1;
                        out_data_next = {{HW{1'b0}}, io_in_data_bits_data[W-1:HW]};
                        out_keep_next = {{HDR_BYTES{1'b0}}, io_in_data_bits_keep[KW-1:HDR_BYTES]};
                        out_last_next = 1'b1;
                    end else begin
                        load_res = 1'b1;
                    end
                end
            end
            ST_MID: begin
                if (in_fire) begin
                    load_out      = 1'b1;
                    load_res      = 1'b1;
                    out_data_next = {io_in_data_bits_data[HW-1:0], res_data};
                    out_keep_next = {io_in_data_bits_keep[HDR_BYTES-1:0], res_keep};
                    out_last_next = io_in_data_bits_last && in_tail_empty;
                end
            end
            ST_FLUSH: begin
                if (data_free) begin
                    load_out      = 1'b1;
                    out_data_next = {{HW{1'b0}}, res_data};
                    out_keep_next = {{HDR_BYTES{1'b0}}, res_keep};
                    out_last_next = 1'b1;
                end
            end
            default: begin
                load_out = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Residual register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_data <= '0;
            res_keep <= '0;
        end else if (load_res) begin
            res_data <= io_in_data_bits_data[W-1:HW];
            res_keep <= io_in_data_bits_keep[KW-1:HDR_BYTES];
        end
    end

    // -----------------------------------------------------------------------
    // Output data slot
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_data_valid     <= 1'b0;
            io_out_data_bits_data <= '0;
            io_out_data_bits_keep <= '0;
            io_out_data_bits_last <= 1'b0;
        end else if (load_out) begin
            io_out_data_valid     <= 1'b1;
            io_out_data_bits_data <= out_data_next;
            io_out_data_bits_keep <= out_keep_next;
            io_out_data_bits_last <= out_last_next;
        end else if (io_out_data_ready) begin
            io_out_data_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Meta slot
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out_meta_valid <= 1'b0;
            io_out_meta_bits  <= '0;
        end else if (load_meta) begin
            io_out_meta_valid <= 1'b1;
            io_out_meta_bits  <= io_in_data_bits_data[HW-1:0];
        end else if (io_out_meta_ready) begin
            io_out_meta_valid <= 1'b0;
        end
    end

endmodule

// File: doc/remove_header.md
# remove_header

Streaming header stripper, the receive-side counterpart of the header-insertion block. It takes a 512-bit packet stream whose first beat carries a 32-bit header in byte lanes 0..3. It emits the header on a separate meta channel and re-aligns the remaining payload down by 4 bytes onto an output packet stream. It sits between the network/DMA stream ingress and consumers that expect metadata and payload as separate channels.

## Interface
- DATA_BYTES, 64, bytes per beat; data width = 8*DATA_BYTES, keep width = DATA_BYTES
- HDR_BYTES, 4, header bytes at the start of each packet; meta width = 8*HDR_BYTES; must be < DATA_BYTES
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- io_in_data_valid / io_in_data_ready  in/out  1  input stream handshake
- io_in_data_bits_data  in  512  byte i = bits [8i+7:8i]
- io_in_data_bits_keep  in  64  byte enables, contiguous from bit 0
- io_in_data_bits_last  in  1  final beat of packet
- io_out_meta_valid / io_out_meta_ready  out/in  1  meta handshake
- io_out_meta_bits  out  32  header = first-beat bytes 0..3
- io_out_data_valid / io_out_data_ready  out/in  1  output stream handshake
- io_out_data_bits_data / _keep / _last  out  512 / 64 / 1  re-aligned payload

## Operation
- Transfer occurs when valid && ready on a cycle edge; valid, once high, holds with stable bits until accepted.
- State FIRST (reset state), MID, FLUSH. Residual register holds the upper DATA_BYTES-HDR_BYTES bytes (res_data 480b, res_keep 60b) of the previous input beat.
- FIRST, beat accepted: meta slot loads data[31:0].
  - If last=0: res <= data[511:32], keep[63:4]; no output beat; go MID.
  - If last=1: output {32'h0, data[511:32]}, keep {4'h0, keep[63:4]}, last=1; stay FIRST. A header-only packet (keep[63:4]=0) still emits one beat with keep=0, last=1.
- MID, beat accepted: output {data[31:0], res_data}, keep {keep[3:0], res_keep}; res <= upper bytes of this beat.
  - last=0: out last=0; stay MID.
  - last=1 and keep[63:4]=0: out last=1; go FIRST.
  - last=1 and keep[63:4]!=0: out last=0; go FLUSH.
- FLUSH: when the output slot is free, emit {32'h0, res_data}, keep {4'h0, res_keep}, last=1; go FIRST. No input is accepted in FLUSH.
- Meta and data channels are independent. Every packet yields exactly one meta and one output packet.
- Reset (asserted at any time, including mid-packet): state=FIRST; io_out_data_valid=0; io_out_meta_valid=0; data/keep/last/meta/residual registers=0. A partial packet is discarded. io_in_data_ready=0 while reset is high.

## Timing
- Output data and meta are 1-entry registered slots. A slot is "free" when valid=0 or its ready=1 in the same cycle.
- io_in_data_ready = !reset && state!=FLUSH && data slot free && (state!=FIRST || meta slot free). It is combinational from the out readies; there is no path from in_valid to in_ready.
- Latency: meta is valid the cycle after the first beat is accepted. A merged output beat is valid the cycle after the completing input beat is accepted. The FLUSH beat is valid the cycle after entering FLUSH, if the slot is free.
- Full throughput: 1 beat/cycle sustained in MID with both readies high. Each packet adds at most one extra output beat (FLUSH) and one bubble.
- A new packet's first beat stalls while the previous meta is unconsumed. The data path never waits on meta otherwise.
- Back-to-back packets: FIRST accepts the next packet's first beat in the cycle after the last-beat output is loaded.

## Test plan
- 2-beat packet: beat0 data=0x01_00001111, keep all-ones; beat1 data=0x02, keep all-ones, last=1 -> meta 0x1111. Out beat0: bits[479:0]=0x01, bits[511:480]=0x2, keep all-ones, last=0. Out beat1: data 0, keep 64'h0FFFFFFFFFFFFFFF, last=1.
- 2-beat packet with beat1 keep=64'hF, last=1 -> single output beat, keep all-ones, last=1, no FLUSH beat.
- Single beat: data=0xAABB_00001111, keep=64'hFF, last=1 -> meta 0x1111; one beat data=0xAABB, keep=0xF, last=1. Header-only beat (keep=0xF) -> one beat with keep=0, last=1.
- Backpressure: io_out_data_ready low for 20 cycles mid-packet, then random toggling over a 3-packet burst -> output byte stream identical to the input minus headers; no loss or duplication; bits stable while valid && !ready.
- Meta stall: io_out_meta_ready held low after packet 1 -> packet 2's first beat sees io_in_data_ready=0 until meta 1 is taken. Packet 1's data completes meanwhile.
- Reset after beat0 of a 3-beat packet -> all valids 0 in the same cycle. After release, a fresh 2-beat packet produces correct output with no residual leakage.
